// File: rtl/vlsu_pkg.sv
// Shared helpers for the VLSU meta-info broadcast logic.
package vlsu_pkg;

    // Advance a ring pointer, wrapping at depth-1; depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vlsu_meta_fork_fifo.sv
// Single consumer FIFO of the meta fork: registered output (no fall-through),
// occupancy counter, synchronous flush. Storage is not reset.
module vlsu_meta_fork_fifo
    import vlsu_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter type         meta_t = logic,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush,
    input  logic            push,
    input  meta_t           push_data,
    output logic            full,
    input  logic            pop,
    output logic            valid,
    output meta_t           data,
    output logic [CntW-1:0] occ
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    meta_t           mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            pop_act;

    assign valid   = (occ != '0);
    assign full    = (occ == CntW'(Depth));
    assign pop_act = pop & valid;
    assign data    = valid ? mem[rd_ptr] : '0;

    // Payload write; the top never pushes while flushing or full.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)    wr_ptr <= PtrW'(wrap_inc(int'(wr_ptr), Depth));
            if (pop_act) rd_ptr <= PtrW'(wrap_inc(int'(rd_ptr), Depth));
            if (push && !pop_act)      occ <= occ + CntW'(1);
            else if (!push && pop_act) occ <= occ - CntW'(1);
        end
    end

    a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i) occ <= CntW'(Depth));
    a_no_ovf:    assert property (@(posedge clk_i) disable iff (rst_i) push |-> !full);

endmodule

// File: rtl/vlsu_meta_fork_n.sv
// N-way buffered broadcast fork for VLSU meta-info. Each consumer owns a FIFO,
// so a slow consumer only stalls the issuer once its own FIFO is full.
module vlsu_meta_fork_n
    import vlsu_pkg::*;
#(
    parameter int unsigned NrConsumers = 2,
    parameter int unsigned Depth       = 2,
    parameter type         meta_t      = logic,
    localparam int unsigned CntW       = $clog2(Depth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                meta_valid_i,
    output logic                                meta_ready_o,
    input  meta_t                               meta_i,
    input  logic [NrConsumers-1:0]              meta_sel_i,
    output logic [NrConsumers-1:0]              cons_valid_o,
    input  logic [NrConsumers-1:0]              cons_ready_i,
    output meta_t [NrConsumers-1:0]             cons_o,
    output logic [NrConsumers-1:0][CntW-1:0]    occ_o,
    output logic                                idle_o
);

    logic [NrConsumers-1:0] full;
    logic                   fire;

    // Ready looks only at registered fullness of selected FIFOs: a same-cycle
    // pop never frees a slot, keeping cons_ready_i off the issuer ready path.
    assign meta_ready_o = !flush_i && !(|(meta_sel_i & full));
    assign fire         = meta_valid_i && meta_ready_o;
    assign idle_o       = !(|cons_valid_o);

    for (genvar g = 0; g < NrConsumers; g++) begin : g_fifo
        vlsu_meta_fork_fifo #(
            .Depth  (Depth),
            .meta_t (meta_t)
        ) u_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush     (flush_i),
            .push      (fire && meta_sel_i[g]),
            .push_data (meta_i),
            .full      (full[g]),
            .pop       (cons_ready_i[g]),
            .valid     (cons_valid_o[g]),
            .data      (cons_o[g]),
            .occ       (occ_o[g])
        );
    end

    a_params: assert property (@(posedge clk_i) (Depth >= 1) && (NrConsumers >= 1));
    a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (meta_valid_i && !meta_ready_o) |=>
            (!meta_valid_i || ($stable(meta_i) && $stable(meta_sel_i))));

endmodule

// File: tb/tb_vlsu_meta_fork_n.sv
// Self-checking bench for vlsu_meta_fork_n: a 3x2 instance (a) and a 3x3 instance (b).
module tb_vlsu_meta_fork_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance a: NrConsumers=3, Depth=2
    logic            flush_a = 0, mv_a = 0, mready_a, idle_a;
    logic [7:0]      meta_a = 0;
    logic [2:0]      sel_a = 0, cr_a = 0, cvalid_a;
    logic [2:0][7:0] cons_a;
    logic [2:0][1:0] occ_a;

    // Instance b: NrConsumers=3, Depth=3
    logic            flush_b = 0, mv_b = 0, mready_b, idle_b;
    logic [7:0]      meta_b = 0;
    logic [2:0]      sel_b = 0, cr_b = 0, cvalid_b;
    logic [2:0][7:0] cons_b;
    logic [2:0][1:0] occ_b;

    vlsu_meta_fork_n #(.NrConsumers(3), .Depth(2), .meta_t(logic [7:0])) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .meta_valid_i(mv_a),
        .meta_ready_o(mready_a), .meta_i(meta_a), .meta_sel_i(sel_a),
        .cons_valid_o(cvalid_a), .cons_ready_i(cr_a), .cons_o(cons_a),
        .occ_o(occ_a), .idle_o(idle_a));

    vlsu_meta_fork_n #(.NrConsumers(3), .Depth(3), .meta_t(logic [7:0])) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .meta_valid_i(mv_b),
        .meta_ready_o(mready_b), .meta_i(meta_b), .meta_sel_i(sel_b),
        .cons_valid_o(cvalid_b), .cons_ready_i(cr_b), .cons_o(cons_b),
        .occ_o(occ_b), .idle_o(idle_b));

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected beats pushed on accept, observed beats pushed on pop.
    logic [7:0] qa[3][$];
    logic [7:0] ga[3][$];
    logic [7:0] qb[3][$];
    logic [7:0] gb[3][$];

    // Record accepts and pops at the edge, before the DUT registers update.
    always @(posedge clk) begin
        if (rst || flush_a) begin
            for (int i = 0; i < 3; i++) begin qa[i].delete(); ga[i].delete(); end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cvalid_a[i] && cr_a[i]) ga[i].push_back(cons_a[i]);
                if (mv_a && mready_a && sel_a[i]) qa[i].push_back(meta_a);
            end
        end
        if (rst || flush_b) begin
            for (int i = 0; i < 3; i++) begin qb[i].delete(); gb[i].delete(); end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cvalid_b[i] && cr_b[i]) gb[i].push_back(cons_b[i]);
                if (mv_b && mready_b && sel_b[i]) qb[i].push_back(meta_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        checks++;
        if (cvalid_a !== 3'b000 || occ_a !== '0 || idle_a !== 1'b1 || mready_a !== 1'b1 || cons_a !== '0) begin
            errors++;
            $display("FAIL reset_a: valid=%b occ=%h idle=%b ready=%b cons=%h, want 000/0/1/1/0",
                     cvalid_a, occ_a, idle_a, mready_a, cons_a);
        end
        checks++;
        if (cvalid_b !== 3'b000 || occ_b !== '0 || idle_b !== 1'b1 || mready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_b: valid=%b occ=%h idle=%b ready=%b, want 000/0/1/1",
                     cvalid_b, occ_b, idle_b, mready_b);
        end
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_fill();
        sel_a = 3'b111; cr_a = 3'b000; mv_a = 1; meta_a = 8'hA1;
        #1;
        checks++;
        if (mready_a !== 1'b1) begin errors++; $display("FAIL fill_ready_a: got %b want 1", mready_a); end
        step();
        meta_a = 8'hB2;
        #1;
        checks++;
        if (mready_a !== 1'b1 || cvalid_a !== 3'b111 || occ_a !== {2'd1, 2'd1, 2'd1}) begin
            errors++;
            $display("FAIL fill_one: ready=%b valid=%b occ=%h want 1/111/15", mready_a, cvalid_a, occ_a);
        end
        checks++;
        if (cons_a !== {8'hA1, 8'hA1, 8'hA1}) begin
            errors++; $display("FAIL fill_latency: cons=%h want a1a1a1", cons_a);
        end
        step();
        meta_a = 8'hC3;
        #1;
        checks++;
        if (mready_a !== 1'b0 || occ_a !== {2'd2, 2'd2, 2'd2}) begin
            errors++; $display("FAIL fill_full: ready=%b occ=%h want 0/2a", mready_a, occ_a);
        end
        step();
        checks++;
        if (mready_a !== 1'b0 || occ_a !== {2'd2, 2'd2, 2'd2} || cons_a[1] !== 8'hA1) begin
            errors++;
            $display("FAIL fill_stall: ready=%b occ=%h cons1=%h want 0/2a/a1", mready_a, occ_a, cons_a[1]);
        end
    endtask

    task automatic test_drain_one();
        cr_a = 3'b001;
        #1;
        checks++;
        if (cvalid_a[0] !== 1'b1 || cons_a[0] !== 8'hA1) begin
            errors++; $display("FAIL drain_first: v=%b d=%h want 1/a1", cvalid_a[0], cons_a[0]);
        end
        step();
        checks++;
        if (cons_a[0] !== 8'hB2 || mready_a !== 1'b0) begin
            errors++; $display("FAIL drain_second: d=%h ready=%b want b2/0", cons_a[0], mready_a);
        end
        step();
        cr_a = 3'b000;
        #1;
        checks++;
        if (occ_a !== {2'd2, 2'd2, 2'd0} || cvalid_a[0] !== 1'b0 || mready_a !== 1'b0) begin
            errors++;
            $display("FAIL drain_blocked: occ=%h v0=%b ready=%b want 28/0/0", occ_a, cvalid_a[0], mready_a);
        end
        checks++;
        if (ga[0].size() != 2) begin
            errors++; $display("FAIL drain_count: got %0d pops want 2", ga[0].size());
        end
        while (ga[0].size() > 0 && qa[0].size() > 0) begin
            logic [7:0] g, e;
            g = ga[0].pop_front();
            e = qa[0].pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL drain_order: got %h want %h", g, e); end
        end
        mv_a = 0;
    endtask

    task automatic test_sel();
        cr_a = 3'b100;
        step();
        step();
        cr_a = 3'b000;
        #1;
        checks++;
        if (occ_a !== {2'd0, 2'd2, 2'd0}) begin
            errors++; $display("FAIL sel_setup: occ=%h want 08", occ_a);
        end
        sel_a = 3'b010;
        #1;
        checks++;
        if (mready_a !== 1'b0) begin errors++; $display("FAIL sel_full_ready: got %b want 0", mready_a); end
        sel_a = 3'b101;
        #1;
        checks++;
        if (mready_a !== 1'b1) begin errors++; $display("FAIL sel_free_ready: got %b want 1", mready_a); end
        mv_a = 1; meta_a = 8'hD4;
        step();
        mv_a = 0;
        #1;
        checks++;
        if (occ_a !== {2'd1, 2'd2, 2'd1} || cons_a !== {8'hD4, 8'hA1, 8'hD4}) begin
            errors++; $display("FAIL sel_masked_push: occ=%h cons=%h want 19/d4a1d4", occ_a, cons_a);
        end
        sel_a = 3'b000; mv_a = 1; meta_a = 8'hE5;
        #1;
        checks++;
        if (mready_a !== 1'b1) begin errors++; $display("FAIL sel_none_ready: got %b want 1", mready_a); end
        step();
        mv_a = 0;
        #1;
        checks++;
        if (occ_a !== {2'd1, 2'd2, 2'd1}) begin
            errors++; $display("FAIL sel_none_discard: occ=%h want 19", occ_a);
        end
        cr_a = 3'b111;
        step();
        step();
        step();
        cr_a = 3'b000;
        #1;
        checks++;
        if (idle_a !== 1'b1 || cvalid_a !== 3'b000) begin
            errors++; $display("FAIL sel_idle: idle=%b valid=%b want 1/000", idle_a, cvalid_a);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ga[i].size() != qa[i].size()) begin
                errors++;
                $display("FAIL sel_count_%0d: got %0d pops want %0d", i, ga[i].size(), qa[i].size());
            end
            while (ga[i].size() > 0 && qa[i].size() > 0) begin
                logic [7:0] g, e;
                g = ga[i].pop_front();
                e = qa[i].pop_front();
                checks++;
                if (g !== e) begin errors++; $display("FAIL sel_order_%0d: got %h want %h", i, g, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        cr_b = 3'b111; sel_b = 3'b111; mv_b = 1;
        for (int k = 0; k < 10; k++) begin
            meta_b = 8'h30 + 8'(k);
            #1;
            checks++;
            if (mready_b !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", k, mready_b); end
            if (k > 0) begin
                checks++;
                if (occ_b !== {2'd1, 2'd1, 2'd1} || cons_b !== {3{8'h30 + 8'(k - 1)}}) begin
                    errors++;
                    $display("FAIL b2b_beat_%0d: occ=%h cons=%h want 15/%h", k, occ_b, cons_b, 8'h30 + 8'(k - 1));
                end
            end
            step();
        end
        mv_b = 0;
        #1;
        checks++;
        if (cons_b !== {3{8'h39}} || occ_b !== {2'd1, 2'd1, 2'd1}) begin
            errors++; $display("FAIL b2b_last: cons=%h occ=%h want 393939/15", cons_b, occ_b);
        end
        step();
        cr_b = 3'b000;
        #1;
        checks++;
        if (idle_b !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b want 1", idle_b); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gb[i].size() != 10 || qb[i].size() != 10) begin
                errors++;
                $display("FAIL b2b_count_%0d: got %0d pops, %0d accepts, want 10", i, gb[i].size(), qb[i].size());
            end
            while (gb[i].size() > 0 && qb[i].size() > 0) begin
                logic [7:0] g, e;
                g = gb[i].pop_front();
                e = qb[i].pop_front();
                checks++;
                if (g !== e) begin errors++; $display("FAIL b2b_order_%0d: got %h want %h", i, g, e); end
            end
        end
    endtask

    task automatic test_flush();
        cr_a = 3'b000; mv_a = 1; sel_a = 3'b011; meta_a = 8'hF6;
        step();
        sel_a = 3'b001; meta_a = 8'h07;
        step();
        sel_a = 3'b111; meta_a = 8'h5A; flush_a = 1;
        #1;
        checks++;
        if (occ_a !== {2'd0, 2'd1, 2'd2} || mready_a !== 1'b0) begin
            errors++; $display("FAIL flush_pre: occ=%h ready=%b want 06/0", occ_a, mready_a);
        end
        step();
        flush_a = 0;
        #1;
        checks++;
        if (occ_a !== '0 || idle_a !== 1'b1 || cvalid_a !== 3'b000 || mready_a !== 1'b1) begin
            errors++;
            $display("FAIL flush_post: occ=%h idle=%b valid=%b ready=%b want 0/1/000/1",
                     occ_a, idle_a, cvalid_a, mready_a);
        end
        step();
        mv_a = 0;
        #1;
        checks++;
        if (occ_a !== {2'd1, 2'd1, 2'd1} || cons_a !== {3{8'h5A}}) begin
            errors++; $display("FAIL flush_next_beat: occ=%h cons=%h want 15/5a5a5a", occ_a, cons_a);
        end
        cr_a = 3'b111;
        step();
        cr_a = 3'b000;
        #1;
        checks++;
        if (idle_a !== 1'b1) begin errors++; $display("FAIL flush_idle: got %b want 1", idle_a); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ga[i].size() != 1 || qa[i].size() != 1) begin
                errors++;
                $display("FAIL flush_count_%0d: got %0d pops, %0d accepts, want 1", i, ga[i].size(), qa[i].size());
            end else begin
                logic [7:0] g, e;
                g = ga[i].pop_front();
                e = qa[i].pop_front();
                checks++;
                if (g !== e || g !== 8'h5A) begin
                    errors++; $display("FAIL flush_data_%0d: got %h want %h", i, g, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_one();
        test_sel();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
